ex_mem_skid_stage: RTL and testbench
====================================

Name: ex_mem_skid_stage

Overview:
- Elastic EX→MEM pipeline boundary, directly downstream of the ALU.
- Captures the ALU result, branch condition and the MEM/WB control bundle for each instruction, then presents them to the MEM stage.
- A 2-entry skid buffer (main + skid register) with valid/ready handshakes on both sides. A MEM-side stall therefore never drops an ALU result, and in_ready is a pure register output with no combinational path from out_ready.
- Supports a synchronous flush on branch redirect.

Parameters:
XLEN, 32, datapath width of ALU result and store data
RD_W, 5, destination register index width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  EX offers an instruction this cycle
in_ready  output  1  stage can accept; registered, equals !skid_valid
in_alu_result  input  XLEN  ALU result
in_bcond  input  1  ALU branch condition
in_is_branch  input  1  instruction is a conditional branch
in_rs2_data  input  XLEN  store data
in_rd  input  RD_W  destination register
in_mem_read  input  1  load
in_mem_write  input  1  store
in_reg_write  input  1  writes register file
in_mem_to_reg  input  1  WB selects memory data
flush  input  1  kill all held and incoming entries
out_valid  output  1  MEM-side entry valid
out_ready  input  1  MEM stage accepts
out_alu_result  output  XLEN  held ALU result
out_rs2_data  output  XLEN  held store data
out_rd  output  RD_W  held destination
out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg  output  1 each  held control, forced 0 when !out_valid
out_br_taken  output  1  out_valid & is_branch & bcond of head entry
perf_stall_cnt  output  32  MEM back-pressure cycle count (see Optional Feature)

Behaviour:
- State: main {valid, payload}, skid {valid, payload}. Outputs always drive main.
- Reset (reset=0, asynchronous): main.valid=0, skid.valid=0, all payload regs=0. Consequently in_ready=1, out_valid=0, all out_* control=0, out_br_taken=0, out_alu_result/out_rs2_data/out_rd=0, perf_stall_cnt=0.
- Reset is honoured mid-transfer: in-flight entries are discarded and no partial state survives.
- Handshakes:
  - accept = in_valid & in_ready
  - drain = out_valid & out_ready
- Next-state, when not flushing:
  - main empty or drain: if skid.valid, main←skid and skid.valid←0; else main←input with main.valid←accept.
  - main full, no drain, accept: skid←input, skid.valid←1. The stage is now full and in_ready=0 next cycle.
  - main full, no drain, no accept: hold.
  - skid.valid=1 implies in_ready=0, so no accept can occur while skid is occupied.
- Latency: input accepted in cycle N appears on out_* in cycle N+1 when the stage is empty. Throughput is 1 per cycle with out_ready held 1.
- Ordering: strict FIFO. The skid entry is always older than any new input.
- flush=1 (synchronous): main.valid←0, skid.valid←0; the same-cycle input is dropped even if in_valid=1. Flush has priority over accept and drain.
- out_valid is not combinationally dependent on in_valid. in_ready is not combinationally dependent on out_ready.
- Payload registers update only on load (no X-propagation on idle); control outputs gated by out_valid.
- out_valid held with no drain: all out_* remain stable until drain or flush.

Optional Feature:
- Macro EX_MEM_STALL_CNT_EN.
- Defined:
  - perf_stall_cnt increments by 1 every cycle with out_valid=1 and out_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset; unaffected by flush.
- Undefined: the counter logic is absent and perf_stall_cnt is tied to 32'h0.

Test Plan:
- Reset pulse (reset=0) mid-stream with both entries full → next edge: out_valid=0, in_ready=1, out_mem_write=0, out_alu_result=0.
- Back-to-back stream, out_ready=1: results 0x10, 0x20, 0x30 on cycles 0–2 → out_alu_result 0x10, 0x20, 0x30 on cycles 1–3; in_ready stays 1.
- out_ready=0 from cycle 1 while sending 0xA, 0xB, 0xC → 0xA held on out; 0xB in skid; in_ready=0 from cycle 2; 0xC not accepted until release. Raise out_ready → 0xA, 0xB, 0xC emerge in order with none lost or duplicated.
- Branch with in_is_branch=1, in_bcond=1, then flush=1 with stage full plus in_valid=1 → out_br_taken=1 before the flush; after the flush out_valid=0, in_ready=1, and the flushed entries never appear.
- Store with rd=5, rs2=0xDEADBEEF, mem_write=1 stalled 4 cycles → outputs stable all 4 cycles. With EX_MEM_STALL_CNT_EN, perf_stall_cnt=4; without it, 0.

Source files
------------

// File: rtl/ex_mem_skid_stage_if.sv
// Handshake and payload bundle between the EX stage, the EX/MEM skid stage and the MEM stage.
// master = EX/MEM environment driving the stage, slave = the stage itself.
interface ex_mem_skid_stage_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_alu_result;
  logic            in_bcond;
  logic            in_is_branch;
  logic [XLEN-1:0] in_rs2_data;
  logic [RD_W-1:0] in_rd;
  logic            in_mem_read;
  logic            in_mem_write;
  logic            in_reg_write;
  logic            in_mem_to_reg;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_alu_result;
  logic [XLEN-1:0] out_rs2_data;
  logic [RD_W-1:0] out_rd;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_reg_write;
  logic            out_mem_to_reg;
  logic            out_br_taken;
  logic [31:0]     perf_stall_cnt;

  modport master (
    output in_valid, in_alu_result, in_bcond, in_is_branch, in_rs2_data, in_rd,
           in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, flush, out_ready,
    input  in_ready, out_valid, out_alu_result, out_rs2_data, out_rd, out_mem_read,
           out_mem_write, out_reg_write, out_mem_to_reg, out_br_taken, perf_stall_cnt
  );

  modport slave (
    input  in_valid, in_alu_result, in_bcond, in_is_branch, in_rs2_data, in_rd,
           in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, flush, out_ready,
    output in_ready, out_valid, out_alu_result, out_rs2_data, out_rd, out_mem_read,
           out_mem_write, out_reg_write, out_mem_to_reg, out_br_taken, perf_stall_cnt
  );
endinterface

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM elastic boundary: 2-entry skid buffer (main + skid) with flush on branch redirect.
// Define EX_MEM_STALL_CNT_EN to build the MEM back-pressure cycle counter.
module ex_mem_skid_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  ex_mem_skid_stage_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rs2_data;
    logic [RD_W-1:0] rd;
    logic            bcond;
    logic            is_branch;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
  } payload_t;

  payload_t in_pl;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  logic     main_valid_q, main_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     accept;
  logic     drain;

  assign in_pl = '{
    alu_result: bus.in_alu_result,
    rs2_data:   bus.in_rs2_data,
    rd:         bus.in_rd,
    bcond:      bus.in_bcond,
    is_branch:  bus.in_is_branch,
    mem_read:   bus.in_mem_read,
    mem_write:  bus.in_mem_write,
    reg_write:  bus.in_reg_write,
    mem_to_reg: bus.in_mem_to_reg
  };

  // in_ready comes straight from the skid flag, so it never sees out_ready
  assign bus.in_ready = ~skid_valid_q;
  assign accept       = bus.in_valid & ~skid_valid_q;
  assign drain        = main_valid_q & bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_pl;
      end
    end else if (accept) begin
      skid_d       = in_pl;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.out_valid      = main_valid_q;
  assign bus.out_alu_result = main_q.alu_result;
  assign bus.out_rs2_data   = main_q.rs2_data;
  assign bus.out_rd         = main_q.rd;
  assign bus.out_mem_read   = main_valid_q & main_q.mem_read;
  assign bus.out_mem_write  = main_valid_q & main_q.mem_write;
  assign bus.out_reg_write  = main_valid_q & main_q.reg_write;
  assign bus.out_mem_to_reg = main_valid_q & main_q.mem_to_reg;
  assign bus.out_br_taken   = main_valid_q & main_q.is_branch & main_q.bcond;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating; flush deliberately leaves the count alone
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= 32'h0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.perf_stall_cnt = stall_cnt_q;
`else
  assign bus.perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: directed scenarios plus random traffic checked against
// a FIFO-of-depth-2 reference model of the stage.
module tb_ex_mem_skid_stage;
  localparam int XLEN = 32;
  localparam int RD_W = 5;
`ifdef EX_MEM_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ex_mem_skid_stage_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

  ex_mem_skid_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        bcond;
    logic        isbr;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        m2r;
  } ent_t;

  ent_t        q[$];
  ent_t        drv_e;
  int unsigned stall_exp;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                              input logic mw);
    ent_t e;
    e.alu = alu; e.rs2 = rs2; e.rd = rd; e.bcond = 1'b0; e.isbr = 1'b0;
    e.mr = 1'b0; e.mw = mw; e.rw = ~mw; e.m2r = 1'b0;
    return e;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.alu = $urandom; e.rs2 = $urandom; e.rd = 5'($urandom);
    e.bcond = 1'($urandom); e.isbr = 1'($urandom); e.mr = 1'($urandom);
    e.mw = 1'($urandom); e.rw = 1'($urandom); e.m2r = 1'($urandom);
    return e;
  endfunction

  task automatic drive(input logic v, input ent_t e);
    drv_e             = e;
    bus.in_valid      = v;
    bus.in_alu_result = e.alu;
    bus.in_rs2_data   = e.rs2;
    bus.in_rd         = e.rd;
    bus.in_bcond      = e.bcond;
    bus.in_is_branch  = e.isbr;
    bus.in_mem_read   = e.mr;
    bus.in_mem_write  = e.mw;
    bus.in_reg_write  = e.rw;
    bus.in_mem_to_reg = e.m2r;
  endtask

  // Compare every output against the reference FIFO
  task automatic check_model(input string tag);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(q.size() < 2));
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() > 0));
    chk({tag, ".perf"}, 64'(bus.perf_stall_cnt), CNT_EN ? 64'(stall_exp) : 64'd0);
    if (q.size() > 0) begin
      chk({tag, ".alu"}, 64'(bus.out_alu_result), 64'(q[0].alu));
      chk({tag, ".rs2"}, 64'(bus.out_rs2_data), 64'(q[0].rs2));
      chk({tag, ".rd"}, 64'(bus.out_rd), 64'(q[0].rd));
      chk({tag, ".ctrl"}, 64'({bus.out_mem_read, bus.out_mem_write, bus.out_reg_write, bus.out_mem_to_reg}),
          64'({q[0].mr, q[0].mw, q[0].rw, q[0].m2r}));
      chk({tag, ".br"}, 64'(bus.out_br_taken), 64'(q[0].isbr & q[0].bcond));
    end else begin
      chk({tag, ".ctrl0"}, 64'({bus.out_mem_read, bus.out_mem_write, bus.out_reg_write, bus.out_mem_to_reg,
                               bus.out_br_taken}), 64'd0);
    end
  endtask

  // One clock: model the stage as a depth-2 FIFO, then check at the falling edge
  task automatic tick(input string tag);
    bit acc, drn, fl, stall;
    ent_t e;
    e     = drv_e;
    acc   = bus.in_valid && (q.size() < 2);
    drn   = (q.size() > 0) && bus.out_ready;
    fl    = bus.flush;
    stall = (q.size() > 0) && !bus.out_ready;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (stall && stall_exp != 32'hFFFF_FFFF) stall_exp++;
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    ent_t e;
    checks = 0; failures = 0; stall_exp = 0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, mk(32'h0, 32'h0, 5'd0, 1'b0));

    // Reset state
    repeat (2) @(negedge clk);
    check_model("reset");
    chk("reset.alu", 64'(bus.out_alu_result), 64'd0);
    chk("reset.rs2", 64'(bus.out_rs2_data), 64'd0);
    chk("reset.rd", 64'(bus.out_rd), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back stream
    bus.out_ready = 1'b1;
    drive(1'b1, mk(32'h10, 32'h1, 5'd1, 1'b0)); tick("b2b0");
    chk("b2b0.val", 64'(bus.out_alu_result), 64'h10); chk("b2b0.rdy", 64'(bus.in_ready), 64'd1);
    drive(1'b1, mk(32'h20, 32'h2, 5'd2, 1'b0)); tick("b2b1");
    chk("b2b1.val", 64'(bus.out_alu_result), 64'h20); chk("b2b1.rdy", 64'(bus.in_ready), 64'd1);
    drive(1'b1, mk(32'h30, 32'h3, 5'd3, 1'b0)); tick("b2b2");
    chk("b2b2.val", 64'(bus.out_alu_result), 64'h30); chk("b2b2.rdy", 64'(bus.in_ready), 64'd1);
    drive(1'b0, drv_e); tick("b2b3");
    chk("b2b3.empty", 64'(bus.out_valid), 64'd0);

    // MEM stall with skid fill, then release
    drive(1'b1, mk(32'hA, 32'h0, 5'd10, 1'b0)); tick("stl0");
    bus.out_ready = 1'b0;
    drive(1'b1, mk(32'hB, 32'h0, 5'd11, 1'b0)); tick("stl1");
    chk("stl1.head", 64'(bus.out_alu_result), 64'hA); chk("stl1.rdy", 64'(bus.in_ready), 64'd0);
    drive(1'b1, mk(32'hC, 32'h0, 5'd12, 1'b0)); tick("stl2");
    chk("stl2.head", 64'(bus.out_alu_result), 64'hA); chk("stl2.rdy", 64'(bus.in_ready), 64'd0);
    tick("stl3");
    bus.out_ready = 1'b1; tick("rel0");
    chk("rel0.head", 64'(bus.out_alu_result), 64'hB); chk("rel0.rdy", 64'(bus.in_ready), 64'd1);
    tick("rel1");
    chk("rel1.head", 64'(bus.out_alu_result), 64'hC);
    drive(1'b0, drv_e); tick("rel2");
    chk("rel2.empty", 64'(bus.out_valid), 64'd0);

    // Branch, then flush with the stage full and a new input offered
    bus.out_ready = 1'b0;
    e = mk(32'h100, 32'h0, 5'd0, 1'b0); e.isbr = 1'b1; e.bcond = 1'b1; e.rw = 1'b0;
    drive(1'b1, e); tick("br0");
    chk("br0.taken", 64'(bus.out_br_taken), 64'd1);
    drive(1'b1, mk(32'h200, 32'h0, 5'd4, 1'b0)); tick("br1");
    bus.flush = 1'b1; drive(1'b1, mk(32'h300, 32'h0, 5'd6, 1'b0)); tick("fl0");
    chk("fl0.valid", 64'(bus.out_valid), 64'd0); chk("fl0.rdy", 64'(bus.in_ready), 64'd1);
    bus.flush = 1'b0; drive(1'b0, drv_e); bus.out_ready = 1'b1; tick("fl1");
    chk("fl1.valid", 64'(bus.out_valid), 64'd0);
    // Flush with main only: the accepted-looking input is dropped
    bus.out_ready = 1'b0;
    drive(1'b1, mk(32'h400, 32'h0, 5'd7, 1'b0)); tick("fl2");
    bus.flush = 1'b1; drive(1'b1, mk(32'h500, 32'h0, 5'd8, 1'b0)); tick("fl3");
    chk("fl3.valid", 64'(bus.out_valid), 64'd0);
    bus.flush = 1'b0; drive(1'b0, drv_e); tick("fl4");
    chk("fl4.valid", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-stream with both entries full
    drive(1'b1, mk(32'h600, 32'h1, 5'd9, 1'b1)); tick("rs0");
    drive(1'b1, mk(32'h700, 32'h2, 5'd9, 1'b1)); tick("rs1");
    #2 reset = 1'b0;
    #1;
    chk("arst.valid", 64'(bus.out_valid), 64'd0);
    chk("arst.rdy", 64'(bus.in_ready), 64'd1);
    chk("arst.mw", 64'(bus.out_mem_write), 64'd0);
    chk("arst.alu", 64'(bus.out_alu_result), 64'd0);
    chk("arst.perf", 64'(bus.perf_stall_cnt), 64'd0);
    q.delete(); stall_exp = 0;
    drive(1'b0, drv_e);
    @(negedge clk);
    reset = 1'b1;
    check_model("arst");

    // Stalled store: outputs stable, stall counter tracks the cycles
    drive(1'b1, mk(32'h44, 32'hDEADBEEF, 5'd5, 1'b1)); tick("st0");
    drive(1'b0, drv_e);
    for (int i = 0; i < 4; i++) begin
      tick("st");
      chk("st.rd", 64'(bus.out_rd), 64'd5);
      chk("st.rs2", 64'(bus.out_rs2_data), 64'hDEADBEEF);
      chk("st.mw", 64'(bus.out_mem_write), 64'd1);
    end
    chk("st.perf", 64'(bus.perf_stall_cnt), CNT_EN ? 64'd4 : 64'd0);
    bus.out_ready = 1'b1; tick("st5");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), rand_ent());
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 19) == 0);
      tick("rnd");
    end
    bus.flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
